// File: rtl/counter_sequencer.sv
// Command-driven sequencer around a WIDTH-bit up-counter: START/PAUSE/RESUME/ABORT, one-cycle done pulse.
// Optional build macro COUNTER_SEQUENCER_AUTO_RELOAD_EN makes a finished run restart itself from zero.
module counter_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_limit,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [1:0] OP_START  = 2'b00;
    localparam logic [1:0] OP_PAUSE  = 2'b01;
    localparam logic [1:0] OP_RESUME = 2'b10;
    localparam logic [1:0] OP_ABORT  = 2'b11;

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_t           state_reg;
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] limit_reg;
    logic [WIDTH-1:0] count_inc;
    logic             accept;
    logic             is_start;
    logic             is_abort;
    logic             is_pause;
    logic             is_resume;

    assign accept    = cmd_valid && (state_reg != S_DONE);
    assign is_start  = accept && (cmd_op == OP_START);
    assign is_abort  = accept && (cmd_op == OP_ABORT);
    assign is_pause  = accept && (cmd_op == OP_PAUSE);
    assign is_resume = accept && (cmd_op == OP_RESUME);
    assign count_inc = count_reg + ONE;

    always_ff @(posedge clock) begin
        if (rst) begin
            state_reg <= S_IDLE;
            count_reg <= ZERO;
            limit_reg <= ZERO;
        end else begin
            unique case (state_reg)
                S_IDLE: begin
                    // The limit is latched even when zero so DONE always holds count at limit_reg.
                    if (is_start) begin
                        count_reg <= ZERO;
                        limit_reg <= cmd_limit;
                        state_reg <= (cmd_limit == ZERO) ? S_DONE : S_RUN;
                    end
                end
                S_RUN, S_PAUSED: begin
                    if (is_start) begin
                        count_reg <= ZERO;
                        limit_reg <= cmd_limit;
                        state_reg <= (cmd_limit == ZERO) ? S_DONE : S_RUN;
                    end else if (is_abort) begin
                        count_reg <= ZERO;
                        state_reg <= S_IDLE;
                    end else if (is_pause && state_reg == S_RUN) begin
                        state_reg <= S_PAUSED;
                    end else if (is_resume && state_reg == S_PAUSED) begin
                        state_reg <= S_RUN;
                    end else if (state_reg == S_RUN) begin
                        // Commands with no meaning in RUN leave the increment untouched.
                        count_reg <= count_inc;
                        if (count_inc == limit_reg) begin
                            state_reg <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
`ifdef COUNTER_SEQUENCER_AUTO_RELOAD_EN
                    if (limit_reg != ZERO) begin
                        count_reg <= ZERO;
                        state_reg <= S_RUN;
                    end else begin
                        state_reg <= S_IDLE;
                    end
`else
                    state_reg <= S_IDLE;
`endif
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign count     = count_reg;
    assign state     = state_reg;
    assign cmd_ready = (state_reg != S_DONE);
    assign done      = (state_reg == S_DONE);
`ifdef COUNTER_SEQUENCER_AUTO_RELOAD_EN
    // A zero-limit DONE is a one-shot even in reload mode, so it is not busy.
    assign busy = (state_reg == S_RUN) || (state_reg == S_PAUSED) ||
                  ((state_reg == S_DONE) && (limit_reg != ZERO));
`else
    assign busy = (state_reg == S_RUN) || (state_reg == S_PAUSED);
`endif

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: directed test-plan scenarios plus randomized commands vs. a behavioural model.
module tb_counter_sequencer;

    localparam int WIDTH = 32;

    logic             clock = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [WIDTH-1:0] cmd_limit = '0;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    int n_checks = 0;
    int n_fail = 0;

    // Model: phase is one of "idle", "run", "paused", "done"; progress and target are plain integers.
    string    m_phase = "idle";
    longint   m_count = 0;
    longint   m_target = 0;
    bit       auto_reload;

    counter_sequencer #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_limit (cmd_limit),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .state     (state)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint phase_code(input string p);
        if (p == "run") return 1;
        if (p == "paused") return 2;
        if (p == "done") return 3;
        return 0;
    endfunction

    task automatic model_step(input bit r, input bit v, input logic [1:0] op, input longint lim);
        bit accepted;
        if (r) begin
            m_phase = "idle"; m_count = 0; m_target = 0;
            return;
        end
        if (m_phase == "done") begin
            if (auto_reload && m_target != 0) begin
                m_phase = "run"; m_count = 0;
            end else begin
                m_phase = "idle";
            end
            return;
        end
        accepted = v;
        if (accepted && op == 2'b00) begin
            m_count = 0; m_target = lim;
            m_phase = (lim == 0) ? "done" : "run";
            return;
        end
        if (accepted && op == 2'b11 && m_phase != "idle") begin
            m_phase = "idle"; m_count = 0;
            return;
        end
        if (accepted && op == 2'b01 && m_phase == "run") begin
            m_phase = "paused";
            return;
        end
        if (accepted && op == 2'b10 && m_phase == "paused") begin
            m_phase = "run";
            return;
        end
        if (m_phase == "run") begin
            m_count++;
            if (m_count == m_target) m_phase = "done";
        end
    endtask

    task automatic compare_all();
        longint exp_busy;
        exp_busy = (m_phase == "run" || m_phase == "paused" ||
                    (auto_reload && m_phase == "done" && m_target != 0)) ? 1 : 0;
        chk("state", state, phase_code(m_phase));
        chk("count", count, m_count);
        chk("busy", busy, exp_busy);
        chk("done", done, (m_phase == "done") ? 1 : 0);
        chk("cmd_ready", cmd_ready, (m_phase == "done") ? 0 : 1);
    endtask

    // One clock cycle: inputs driven from the falling edge, model advanced on the rising edge, compare on the next falling edge.
    task automatic cycle(input bit r, input bit v, input logic [1:0] op, input longint lim);
        rst = r; cmd_valid = v; cmd_op = op; cmd_limit = lim[WIDTH-1:0];
        @(posedge clock);
        model_step(r, v, op, lim);
        @(negedge clock);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'b00, 0);
    endtask

    initial begin
        int first_done;
        int done_edges[$];
`ifdef COUNTER_SEQUENCER_AUTO_RELOAD_EN
        auto_reload = 1'b1;
`else
        auto_reload = 1'b0;
`endif
        @(negedge clock);
        cycle(1'b1, 1'b0, 2'b00, 0);
        cycle(1'b1, 1'b0, 2'b00, 0);
        chk("reset_state", state, 0);
        chk("reset_count", count, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_ready", cmd_ready, 1);

        // START L=5: count 0..5 over E0..E5, done in the cycle after E5.
        cycle(1'b0, 1'b1, 2'b00, 5);
        chk("l5_e0_count", count, 0);
        chk("l5_e0_busy", busy, 1);
        for (int k = 1; k <= 5; k++) begin
            idle(1);
            chk($sformatf("l5_e%0d_count", k), count, k);
        end
        chk("l5_done", done, 1);
        idle(1);
        chk("l5_after_done", done, 0);
        if (!auto_reload) begin
            chk("l5_idle_state", state, 0);
            chk("l5_idle_count", count, 5);
            chk("l5_idle_busy", busy, 0);
        end
        cycle(1'b0, 1'b1, 2'b11, 0);

        // START L=10, pause at count=3 for 4 non-counting edges, done 14 edges after START.
        cycle(1'b0, 1'b1, 2'b00, 10);
        idle(3);
        chk("p_count_before", count, 3);
        cycle(1'b0, 1'b1, 2'b01, 0);
        chk("p_paused_state", state, 2);
        chk("p_hold1", count, 3);
        idle(2);
        chk("p_hold2", count, 3);
        cycle(1'b0, 1'b1, 2'b10, 0);
        chk("p_resume_count", count, 3);
        first_done = -1;
        for (int n = 8; n <= 30 && first_done < 0; n++) begin
            idle(1);
            if (done) first_done = n;
        end
        chk("p_done_edge", first_done, 14);
        cycle(1'b0, 1'b1, 2'b11, 0);

        // START L=8, ABORT at count=6.
        cycle(1'b0, 1'b1, 2'b00, 8);
        idle(6);
        chk("a_count_before", count, 6);
        cycle(1'b0, 1'b1, 2'b11, 0);
        chk("a_state", state, 0);
        chk("a_count", count, 0);
        chk("a_done", done, 0);
        idle(10);

        // START L=0: DONE straight away, not ready during it.
        cycle(1'b0, 1'b1, 2'b00, 0);
        chk("z_state", state, 3);
        chk("z_count", count, 0);
        chk("z_ready", cmd_ready, 0);
        cycle(1'b0, 1'b1, 2'b00, 7);
        chk("z_cmd_ignored_in_done", state, 0);
        idle(1);

        // PAUSE in the cycle where count=L-1 beats the terminal count.
        cycle(1'b0, 1'b1, 2'b00, 4);
        idle(3);
        cycle(1'b0, 1'b1, 2'b01, 0);
        chk("t_state", state, 2);
        chk("t_count", count, 3);
        chk("t_done", done, 0);
        cycle(1'b0, 1'b1, 2'b11, 0);

        // Reset in mid-run.
        cycle(1'b0, 1'b1, 2'b00, 9);
        idle(4);
        chk("r_count_before", count, 4);
        cycle(1'b1, 1'b0, 2'b00, 0);
        chk("r_state", state, 0);
        chk("r_count", count, 0);
        chk("r_busy", busy, 0);
        chk("r_ready", cmd_ready, 1);
        cycle(1'b0, 1'b0, 2'b00, 0);

        if (auto_reload) begin
            cycle(1'b0, 1'b1, 2'b00, 3);
            for (int n = 1; n <= 12; n++) begin
                idle(1);
                if (done) done_edges.push_back(n);
            end
            chk("ar_pulses", done_edges.size(), 3);
            if (done_edges.size() == 3) begin
                chk("ar_pulse0", done_edges[0], 3);
                chk("ar_pulse1", done_edges[1], 7);
                chk("ar_pulse2", done_edges[2], 11);
            end
            cycle(1'b0, 1'b1, 2'b11, 0);
            chk("ar_abort_count", count, 0);
            chk("ar_abort_state", state, 0);
        end

        // Randomized commands, mostly short limits with occasional large ones.
        for (int i = 0; i < 3000; i++) begin
            bit     r;
            bit     v;
            logic [1:0] op;
            longint lim;
            r  = ($urandom_range(0, 199) == 0);
            v  = ($urandom_range(0, 3) == 0);
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0)
                lim = longint'($urandom());
            else
                lim = $urandom_range(0, 12);
            cycle(r, v, op, lim);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Command-driven controller that sequences a WIDTH-bit up-counter through load, run, pause, abort and terminal-count phases. It sits between a host command interface and the counter datapath. It turns single-cycle commands into counter enables and clears, and it reports completion with a one-cycle `done` pulse. The counter register lives inside this block; `count` is its output.

## Interface
Parameters:
- `WIDTH`, default 32: counter and limit width.

Ports:
- `clock`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command this cycle.
- `cmd_op`  in  2  command code: 00 START, 01 PAUSE, 10 RESUME, 11 ABORT.
- `cmd_limit`  in  WIDTH  terminal count; sampled only on an accepted START.
- `count`  out  WIDTH  current counter value (registered).
- `busy`  out  1  high in RUN or PAUSED.
- `done`  out  1  one-cycle pulse, high while in DONE.
- `state`  out  2  IDLE=0, RUN=1, PAUSED=2, DONE=3.

## Operation
- A command is accepted on a rising edge where `cmd_valid & cmd_ready` = 1.
- `cmd_ready` = 1 in IDLE, RUN and PAUSED; 0 in DONE.
- A command that is not listed for the current state is accepted and has no effect.
- An internal `limit_r` register holds the latched terminal count.

IDLE:
- START with `cmd_limit`=0: `count` <= 0, go to DONE.
- START with `cmd_limit`=L>0: `count` <= 0, `limit_r` <= L, go to RUN.
- Otherwise `count` holds.

RUN:
- With no command: `count` <= `count`+1 each cycle.
- When the increment takes `count` to `limit_r`, go to DONE.
- PAUSE: go to PAUSED; no increment on that edge.
- ABORT: go to IDLE, `count` <= 0; `done` does not pulse.
- START: restart; `count` <= 0, `limit_r` <= `cmd_limit`, apply the zero-limit rule as in IDLE.

PAUSED:
- `count` holds.
- RESUME: go to RUN; incrementing restarts on the following edge.
- ABORT and START behave as in RUN.

DONE:
- Lasts exactly one cycle with `done`=1, then goes to IDLE.
- `count` holds at `limit_r`.

Priority rules:
- `rst` overrides everything.
- An accepted command overrides terminal count in the same cycle. For example, PAUSE at `count`=L-1 goes to PAUSED with `count`=L-1, and `done` does not pulse.
- `count` never wraps, because the maximum limit is 2^WIDTH-1.

## Timing
- Reset values: `state`=IDLE, `count`=0, `limit_r`=0, `done`=0, `busy`=0, `cmd_ready`=1.
- START is accepted at edge E0:
  - E0: `count`=0 and `busy`=1.
  - Edge Ek (k ≤ L): `count`=k.
  - Edge EL: `state`=DONE and `done`=1.
  - Edge EL+1: `state`=IDLE, `done`=0, `busy`=0.
- Each paused cycle extends the run by exactly one cycle.
- All outputs are registered or decoded from `state`; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `COUNTER_SEQUENCER_AUTO_RELOAD_EN`.
- When defined:
  - DONE goes to RUN instead of IDLE, with `count` <= 0 on that edge.
  - The result is periodic `done` pulses every L+1 cycles.
  - `busy` stays 1 in DONE.
  - Only ABORT, or a new START, leaves the cycle.
  - The zero-limit START still produces a single DONE and then IDLE.
- When undefined: one-shot behaviour, exactly as described above.

## Test plan
- Reset, then START with L=5: `count` steps 0..5 over edges E0..E5, `done`=1 only in the cycle after E5, then IDLE with `count`=5 and `busy`=0.
- START L=10, PAUSE when `count`=3, hold 4 cycles, then RESUME: `count` stays 3 while paused, and `done` pulses 14 edges after START acceptance.
- START L=8, ABORT when `count`=6: the next state is IDLE with `count`=0; `done` never asserts.
- START L=0: DONE on the next cycle with `count`=0; `cmd_ready`=0 during that cycle. Also, in the cycle where `count`=L-1, issue PAUSE: PAUSED with `count`=L-1 and no `done`.
- Assert `rst` mid-run (`count`=4): on the next edge all outputs take their reset values.
- With `COUNTER_SEQUENCER_AUTO_RELOAD_EN`, START L=3: `done` pulses at E3, E7, E11; ABORT stops it and `count` returns to 0.
